// File: rtl/bitstream_sequencer_if.sv
// Handshake and result bundle between the bitstream sequencer and the block that requests evaluations.
// The abort/aborted pair exists only when BITSTREAM_SEQ_ABORT_EN is defined.
interface bitstream_sequencer_if #(
    parameter int CW = 9
);
    logic          start;
    logic          stream_in;
    logic          layer_n_rst;
    logic [31:0]   seed_out;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [CW-1:0] result;
`ifdef BITSTREAM_SEQ_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    modport master (
`ifdef BITSTREAM_SEQ_ABORT_EN
        output abort,
        input  aborted,
`endif
        output start, stream_in,
        input  layer_n_rst, seed_out, busy, done, result_valid, result
    );

    modport slave (
`ifdef BITSTREAM_SEQ_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  start, stream_in,
        output layer_n_rst, seed_out, busy, done, result_valid, result
    );
endinterface

// File: rtl/bitstream_sequencer.sv
// Reseeds the datapath, skips WARMUP cycles, counts ones over STREAM_LEN cycles; done is high 2+WARMUP+STREAM_LEN cycles after start.
// No backpressure: start is ignored while busy; BITSTREAM_SEQ_ABORT_EN adds an abort input and aborted pulse.
module bitstream_sequencer #(
    parameter int          STREAM_LEN = 256,
    parameter int          WARMUP     = 2,
    parameter logic [31:0] SEED       = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    bitstream_sequencer_if.slave  bus
);
    localparam int          CW        = $clog2(STREAM_LEN + 1);
    localparam logic [15:0] WARM_LAST = 16'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [15:0] RUN_LAST  = 16'(STREAM_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WARM, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] result_q, result_d;
    logic          valid_q, valid_d;
`ifdef BITSTREAM_SEQ_ABORT_EN
    logic          aborted_q, aborted_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
`ifdef BITSTREAM_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
`ifdef BITSTREAM_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        valid_d   = valid_q;
`ifdef BITSTREAM_SEQ_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (WARMUP > 0) ? WARM : RUN;
            end
            WARM: begin
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                // stream_in is only looked at here, so X elsewhere cannot leak into state
                if (bus.stream_in) begin
                    acc_d = acc_q + CW'(1);
                end
                if (cnt_q == RUN_LAST) begin
                    state_d  = DONE;
                    result_d = acc_d;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef BITSTREAM_SEQ_ABORT_EN
        // abort overrides any in-flight progress; published result is left untouched
        if (bus.abort && (state_q == LOAD || state_q == WARM || state_q == RUN)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            acc_d     = acc_q;
            result_d  = result_q;
            valid_d   = valid_q;
            aborted_d = 1'b1;
        end
`endif
    end

    assign bus.layer_n_rst  = !rst && (state_q != LOAD);
    assign bus.seed_out     = SEED;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
`ifdef BITSTREAM_SEQ_ABORT_EN
    assign bus.aborted      = aborted_q;
`endif
endmodule

// File: tb/tb_bitstream_sequencer.sv
// Directed bench for bitstream_sequencer: timeline model of evaluation phases checked every cycle, plus literal latency/count checks.
module tb_bitstream_sequencer;
    localparam int          L    = 16;
    localparam int          W    = 2;
    localparam logic [31:0] SEED = 32'hA5C3_0F01;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bitstream_sequencer_if #(.CW(5)) m_if ();
    bitstream_sequencer_if #(.CW(1)) s_if ();

    bitstream_sequencer #(.STREAM_LEN(L), .WARMUP(W), .SEED(SEED)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    bitstream_sequencer #(.STREAM_LEN(1), .WARMUP(0), .SEED(32'd0)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: an evaluation is a timeline anchored at its LOAD cycle m_load.
    // Phase p = cycle - m_load: 0 LOAD, 1..W warm-up, W+1..W+L counted, W+L+1 DONE.
    bit m_active  = 1'b0;
    int m_load    = 0;
    int m_acc     = 0;
    int m_result  = 0;
    bit m_valid   = 1'b0;
    bit m_aborted = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_acc     <= 0;
            m_result  <= 0;
            m_valid   <= 1'b0;
            m_aborted <= 1'b0;
        end else begin
            m_aborted <= 1'b0;
            if (!m_active) begin
                if (m_if.start) begin
                    m_active <= 1'b1;
                    m_load   <= cyc + 1;
                    m_valid  <= 1'b0;
                    m_acc    <= 0;
                end
`ifdef BITSTREAM_SEQ_ABORT_EN
            end else if (m_if.abort && (cyc - m_load) <= W + L) begin
                m_active  <= 1'b0;
                m_aborted <= 1'b1;
`endif
            end else if ((cyc - m_load) >= W + 1 && (cyc - m_load) <= W + L) begin
                m_acc <= m_acc + int'(m_if.stream_in);
                if ((cyc - m_load) == W + L) begin
                    m_result <= m_acc + int'(m_if.stream_in);
                    m_valid  <= 1'b1;
                end
            end else if ((cyc - m_load) == W + L + 1) begin
                m_active <= 1'b0;
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", m_if.busy, m_active);
            chk("layer_n_rst", m_if.layer_n_rst, !rst && !(m_active && cyc == m_load));
            chk("done", m_if.done, m_active && cyc == m_load + W + L + 1);
            chk("result_valid", m_if.result_valid, m_valid);
            chk("result", m_if.result, m_result);
            chk("seed_out", m_if.seed_out, SEED);
`ifdef BITSTREAM_SEQ_ABORT_EN
            chk("aborted", m_if.aborted, m_aborted);
`endif
        end
    end

    int done_cnt   = 0;
    int done_cyc[8];
    int s_done_cnt = 0;
    int s_done_cyc = 0;
    int ab_cyc     = -1;
    always @(negedge clk) begin
        if (m_if.done === 1'b1) begin
            if (done_cnt < 8) done_cyc[done_cnt] <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (s_if.done === 1'b1) begin
            s_done_cyc <= cyc;
            s_done_cnt <= s_done_cnt + 1;
        end
`ifdef BITSTREAM_SEQ_ABORT_EN
        if (m_if.aborted === 1'b1) ab_cyc <= cyc;
`endif
    end

    // stream_in driver, keyed on the cycle offset from the start request
    int mode = 3;
    int sc   = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            0: m_if.stream_in = 1'b1;
            1: begin
                if ((cyc - sc) >= W + 2 && (cyc - sc) <= W + L + 1)
                    m_if.stream_in = ((cyc - sc) % 2 == 0);
                else
                    m_if.stream_in = 1'bx;
            end
            2: m_if.stream_in = ((cyc - sc) == 2 || (cyc - sc) == 3);
            default: m_if.stream_in = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input int md, input int exp_res, input string nm);
        int d0;
        d0 = done_cnt;
        sc = cyc;
        mode = md;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        chk({nm, "_done_count"}, done_cnt, d0 + 1);
        if (d0 < 8) chk({nm, "_latency"}, done_cyc[d0] - sc, 2 + W + L);
        chk({nm, "_result"}, m_if.result, exp_res);
        chk({nm, "_model_result"}, m_result, exp_res);
        chk({nm, "_valid"}, m_if.result_valid, 1);
        mode = 3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        m_if.start = 1'b0;
        m_if.stream_in = 1'b0;
        s_if.start = 1'b0;
        s_if.stream_in = 1'b0;
`ifdef BITSTREAM_SEQ_ABORT_EN
        m_if.abort = 1'b0;
        s_if.abort = 1'b0;
`endif
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("rst_busy", m_if.busy, 0);
        chk("rst_layer_n_rst", m_if.layer_n_rst, 0);
        chk("rst_result", m_if.result, 0);
        chk("rst_valid", m_if.result_valid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_layer_n_rst", m_if.layer_n_rst, 1);
        chk("post_rst_busy", m_if.busy, 0);

        eval(0, 16, "ones");
        eval(1, 8, "alternating");
        eval(2, 0, "warm_only");

        // start held for 40 cycles: second evaluation starts after DONE returns to IDLE
        d0 = done_cnt;
        sc = cyc;
        mode = 0;
        m_if.start = 1'b1;
        repeat (40) tick();
        m_if.start = 1'b0;
        repeat (6) tick();
        chk("held_done_count", done_cnt, d0 + 2);
        chk("held_first_done", done_cyc[d0] - sc, 20);
        chk("held_second_done", done_cyc[d0 + 1] - sc, 41);
        chk("held_result", m_if.result, 16);
        mode = 3;
        repeat (2) tick();

        // start re-asserted in cycles 3..15 of a running evaluation must not queue
        d0 = done_cnt;
        sc = cyc;
        mode = 0;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        while (cyc - sc < 3) tick();
        m_if.start = 1'b1;
        while (cyc - sc < 16) tick();
        m_if.start = 1'b0;
        repeat (30) tick();
        chk("noqueue_done_count", done_cnt, d0 + 1);
        chk("noqueue_latency", done_cyc[d0] - sc, 20);
        mode = 3;

        // asynchronous reset in the middle of RUN
        d0 = done_cnt;
        sc = cyc;
        mode = 0;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        while (cyc - sc < 10) tick();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", m_if.busy, 0);
        chk("async_rst_done", m_if.done, 0);
        chk("async_rst_layer_n_rst", m_if.layer_n_rst, 0);
        chk("async_rst_valid", m_if.result_valid, 0);
        chk("async_rst_result", m_if.result, 0);
        repeat (2) tick();
        rst = 1'b0;
        mode = 3;
        repeat (30) tick();
        chk("aborted_run_no_done", done_cnt, d0);
        eval(1, 8, "after_rst");

        // WARMUP=0, STREAM_LEN=1 instance
        s_if.stream_in = 1'b1;
        d0 = s_done_cnt;
        sc = cyc;
        s_if.start = 1'b1;
        tick();
        s_if.start = 1'b0;
        for (int i = 0; i < 10 && s_done_cnt == d0; i++) tick();
        chk("small_done_count", s_done_cnt, d0 + 1);
        chk("small_latency", s_done_cyc - sc, 3);
        chk("small_result", s_if.result, 1);
        chk("small_valid", s_if.result_valid, 1);
        s_if.stream_in = 1'b0;

`ifdef BITSTREAM_SEQ_ABORT_EN
        d0 = done_cnt;
        sc = cyc;
        mode = 0;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        while (cyc - sc < 8) tick();
        m_if.abort = 1'b1;
        tick();
        m_if.abort = 1'b0;
        chk("abort_pulse", m_if.aborted, 1);
        chk("abort_busy", m_if.busy, 0);
        chk("abort_valid", m_if.result_valid, 0);
        repeat (25) tick();
        chk("abort_pulse_cycle", ab_cyc - sc, 9);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_result_kept", m_if.result, 8);
        mode = 3;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitstream_sequencer.md
BITSTREAM_SEQUENCER -- requirements
Module: bitstream_sequencer

Interface
REQ-001 Parameter STREAM_LEN, default 256: number of bitstream cycles counted per evaluation; legal range 1..65535.
REQ-002 Parameter WARMUP, default 2: cycles discarded after datapath reseed to cover datapath pipeline latency; legal range 0..255.
REQ-003 Parameter SEED, default 0: passed through unchanged on seed_out for the datapath generators.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  evaluation request; sampled only in IDLE.
REQ-007 stream_in  input  1  bitstream output of the neuron/layer datapath.
REQ-008 layer_n_rst  output  1  active-low reseed of datapath generators.
REQ-009 seed_out  output  32  equals SEED, constant.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle pulse when result updates.
REQ-012 result_valid  output  1  high while result holds a completed evaluation.
REQ-013 result  output  CW  count of ones in the evaluation window; CW = $clog2(STREAM_LEN+1).

Function
REQ-014 FSM states IDLE, LOAD, WARM, RUN, DONE; one state per clock minimum.
REQ-015 IDLE -> LOAD when start=1; otherwise remain in IDLE.
REQ-016 LOAD lasts exactly 1 cycle with layer_n_rst=0; layer_n_rst=1 in all other states.
REQ-017 LOAD -> WARM if WARMUP>0, else directly to RUN.
REQ-018 WARM lasts exactly WARMUP cycles; stream_in ignored.
REQ-019 RUN lasts exactly STREAM_LEN cycles; the accumulator increments by 1 on each RUN cycle where stream_in=1.
REQ-020 Accumulator is CW bits, cleared in LOAD, and never wraps; all-ones input yields STREAM_LEN.
REQ-021 RUN -> DONE after the last counted cycle; in DONE, result is loaded from the accumulator, done=1, and result_valid=1; DONE -> IDLE after 1 cycle.
REQ-022 Latency: with start sampled at edge 0, done is high in cycle 2+WARMUP+STREAM_LEN.
REQ-023 result_valid clears on the LOAD cycle of the next evaluation; result holds its previous value until DONE.
REQ-024 start while busy is ignored, with no queuing; start asserted during DONE is ignored, and a held start is accepted on the following IDLE cycle.
REQ-025 stream_in is sampled as a registered input; X on stream_in outside RUN shall not affect state.

Reset
REQ-026 rst=1 forces IDLE immediately, independent of clk.
REQ-027 During reset: layer_n_rst=0, busy=0, done=0, result_valid=0, result=0, accumulator=0.
REQ-028 Reset mid-evaluation discards the partial count; no done is produced for the aborted run.
REQ-029 After rst deasserts, the block is in IDLE with layer_n_rst=1 on the first clock edge.

Configuration
REQ-030 Macro BITSTREAM_SEQ_ABORT_EN: when defined, adds port abort (input, 1) and port aborted (output, 1-cycle pulse).
REQ-031 With BITSTREAM_SEQ_ABORT_EN defined: abort=1 in LOAD, WARM or RUN goes to IDLE on the next edge with aborted=1 and done=0; result and result_valid keep their pre-abort values (result_valid already 0 after LOAD); abort in IDLE or DONE is ignored.
REQ-032 Without BITSTREAM_SEQ_ABORT_EN: no abort or aborted ports, and every accepted start runs to DONE unless rst is asserted.

Verification (STREAM_LEN=16, WARMUP=2 unless stated)
REQ-033 start pulse at edge 0, stream_in=1 constantly -> layer_n_rst=0 in cycle 1, done in cycle 20, result=16, result_valid=1.
REQ-034 stream_in alternating 1/0 throughout RUN -> result=8; stream_in=1 only during WARM -> result=0.
REQ-035 start held high for 40 cycles -> two evaluations with done in cycles 20 and 41; start asserted in cycles 3..15 is not queued.
REQ-036 rst asserted at cycle 10 mid-RUN -> outputs at reset values asynchronously, no done, next start completes normally with the correct count.
REQ-037 WARMUP=0, STREAM_LEN=1, stream_in=1 -> done in cycle 3, result=1, CW=1.
REQ-038 With BITSTREAM_SEQ_ABORT_EN defined, abort at cycle 8 -> aborted pulse in cycle 9, IDLE, done never asserted, result_valid=0.
